// File: rtl/overlap_accum_seq_if.sv
// Stream bundle between the sub-multiplier array (master) and the overlap accumulator (slave).
// Carries the part input handshake, the result output handshake and the framing error pulse.
interface overlap_accum_seq_if #(
    parameter int H     = 3,
    parameter int NPART = 3
);
    localparam int IN_W  = 2*H - 1;
    localparam int OUT_W = (NPART + 1)*H - 1;

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, frame_err
    );
endinterface

// File: rtl/overlap_accum_seq.sv
// Streams NPART GF(2) partial products and XOR-places part k at offset k*H, emitting the
// overlapped result through a one-entry output buffer (optional Karatsuba middle-term fold).
module overlap_accum_seq #(
    parameter int H     = 3,
    parameter int NPART = 3,
    parameter int KMODE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    overlap_accum_seq_if.slave bus
);
    localparam int OUT_W = (NPART + 1)*H - 1;
    localparam int IDX_W = $clog2(NPART);

    if (KMODE != 0 && NPART != 3) begin : g_bad_kmode
        $error("overlap_accum_seq: KMODE=1 requires NPART==3");
    end
    if (NPART < 2) begin : g_bad_npart
        $error("overlap_accum_seq: NPART must be at least 2");
    end

    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] contrib;
    logic [OUT_W-1:0] out_data_r;
    logic             out_valid_r;
    logic             frame_err_r;
    logic             is_last;
    logic             accept;
    logic             load;

    assign is_last      = (idx == IDX_W'(NPART - 1));
    assign bus.in_ready = !(is_last && out_valid_r && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = accept && is_last && !clr;

    // Karatsuba mode folds parts 0 and 2 into the middle term as well.
    always_comb begin
        ext     = OUT_W'(bus.in_data);
        contrib = ext << (int'(idx) * H);
        if (KMODE != 0 && (int'(idx) == 0 || int'(idx) == 2)) begin
            contrib = contrib ^ (ext << H);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
        end else if (clr) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            if (is_last) begin
                idx <= '0;
                acc <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
                acc <= acc ^ contrib;
            end
        end
    end

    // A fresh result may replace the one being consumed in the same cycle without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (load) begin
            out_data_r  <= acc ^ contrib;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= accept && !clr && (bus.in_last != is_last);
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_overlap_accum_seq.sv
// Drives four accumulators (H=3, H=3 Karatsuba, H=2, H=8) with shared handshakes and
// scoreboards each result against an XOR-of-shifted-parts reference.
module tb_overlap_accum_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic valid;
    logic last;
    logic out_ready;

    logic [63:0] din  [4];
    logic [63:0] dout [4];
    logic        ov   [4];
    logic        rdy  [4];
    logic        ferr [4];

    int hs [4] = '{3, 3, 2, 8};
    bit km [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic [63:0] exp_q [4][$];
    logic [63:0] m_parts [4][3];
    int          m_idx;
    bit          m_ov;
    bit          err_exp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    overlap_accum_seq_if #(.H(3), .NPART(3)) bus0 ();
    overlap_accum_seq_if #(.H(3), .NPART(3)) bus1 ();
    overlap_accum_seq_if #(.H(2), .NPART(3)) bus2 ();
    overlap_accum_seq_if #(.H(8), .NPART(3)) bus3 ();

    overlap_accum_seq #(.H(3), .NPART(3), .KMODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus0.slave));
    overlap_accum_seq #(.H(3), .NPART(3), .KMODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus1.slave));
    overlap_accum_seq #(.H(2), .NPART(3), .KMODE(0)) dut2 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus2.slave));
    overlap_accum_seq #(.H(8), .NPART(3), .KMODE(0)) dut3 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus3.slave));

    assign bus0.in_data = din[0][4:0];
    assign bus1.in_data = din[1][4:0];
    assign bus2.in_data = din[2][2:0];
    assign bus3.in_data = din[3][14:0];
    assign bus0.in_valid = valid;
    assign bus1.in_valid = valid;
    assign bus2.in_valid = valid;
    assign bus3.in_valid = valid;
    assign bus0.in_last = last;
    assign bus1.in_last = last;
    assign bus2.in_last = last;
    assign bus3.in_last = last;
    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;
    assign bus2.out_ready = out_ready;
    assign bus3.out_ready = out_ready;

    assign dout[0] = 64'(bus0.out_data);
    assign dout[1] = 64'(bus1.out_data);
    assign dout[2] = 64'(bus2.out_data);
    assign dout[3] = 64'(bus3.out_data);
    assign ov[0] = bus0.out_valid;
    assign ov[1] = bus1.out_valid;
    assign ov[2] = bus2.out_valid;
    assign ov[3] = bus3.out_valid;
    assign rdy[0] = bus0.in_ready;
    assign rdy[1] = bus1.in_ready;
    assign rdy[2] = bus2.in_ready;
    assign rdy[3] = bus3.in_ready;
    assign ferr[0] = bus0.frame_err;
    assign ferr[1] = bus1.frame_err;
    assign ferr[2] = bus2.frame_err;
    assign ferr[3] = bus3.frame_err;

    function automatic logic [63:0] part_mask(int k);
        return (64'd1 << (2*hs[k] - 1)) - 64'd1;
    endfunction

    // The reference product: each part XORed in at k*H, plus the Karatsuba middle-term fold.
    function automatic logic [63:0] ref_result(int h, bit kmode, logic [63:0] p0, logic [63:0] p1, logic [63:0] p2);
        logic [63:0] r;
        r = p0 ^ (p1 << h) ^ (p2 << (2*h));
        if (kmode) r = r ^ (p0 << h) ^ (p2 << h);
        return r;
    endfunction

    task automatic checkOutput(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model then decides what the coming edge must do.
    task automatic applyStimulus(input bit v, input bit lst, input logic [63:0] data,
                                 input bit rnd, input bit ordy, input bit c);
        bit exp_ready;
        bit acc_now;
        bit loaded;
        @(negedge clk);
        valid     = v;
        last      = lst;
        out_ready = ordy;
        clr       = c;
        for (int k = 0; k < 4; k++) din[k] = (rnd ? {$urandom, $urandom} : data) & part_mask(k);
        #2;
        exp_ready = !(m_idx == 2 && m_ov && !ordy);
        for (int k = 0; k < 4; k++) checkOutput("in_ready", k, 64'(rdy[k]), 64'(exp_ready));
        acc_now = v && exp_ready;
        loaded  = 1'b0;
        err_exp = acc_now && !c && (lst != (m_idx == 2));
        if (c) begin
            m_idx = 0;
        end else if (acc_now) begin
            for (int k = 0; k < 4; k++) m_parts[k][m_idx] = din[k];
            if (m_idx == 2) begin
                for (int k = 0; k < 4; k++)
                    exp_q[k].push_back(ref_result(hs[k], km[k], m_parts[k][0], m_parts[k][1], m_parts[k][2]));
                m_idx  = 0;
                loaded = 1'b1;
            end else begin
                m_idx++;
            end
        end
        if (loaded) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
    endtask

    task automatic resetMidFrame();
        @(negedge clk);
        valid     = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("rst_out_valid", k, 64'(ov[k]), 64'd0);
            checkOutput("rst_out_data", k, dout[k], 64'd0);
            checkOutput("rst_frame_err", k, 64'(ferr[k]), 64'd0);
            checkOutput("rst_in_ready", k, 64'(rdy[k]), 64'd1);
            exp_q[k].delete();
        end
        m_idx   = 0;
        m_ov    = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic sendFrame(input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2, input bit ordy_last);
        applyStimulus(1'b1, 1'b0, p0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, p1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, p2, 1'b0, ordy_last, 1'b0);
    endtask

    // Monitor: compares every presented result with the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] exp;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("out_valid", k, 64'(ov[k]), 64'(exp_q[k].size() > 0));
            if (ov[k] && out_ready && exp_q[k].size() > 0) begin
                exp = exp_q[k].pop_front();
                checkOutput("out_data", k, dout[k], exp);
            end
            checkOutput("frame_err", k, 64'(ferr[k]), 64'(err_exp));
        end
    end

    initial begin
        bit flip;
        bit c;
        rst_n     = 1'b0;
        clr       = 1'b0;
        valid     = 1'b0;
        last      = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = 64'd0;
        m_idx   = 0;
        m_ov    = 1'b0;
        err_exp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("reset_out_valid", k, 64'(ov[k]), 64'd0);
            checkOutput("reset_out_data", k, dout[k], 64'd0);
            checkOutput("reset_frame_err", k, 64'(ferr[k]), 64'd0);
        end
        #2;
        rst_n = 1'b1;

        $display("[TB] basic frame, plain and Karatsuba");
        sendFrame(64'h15, 64'h1F, 64'h03, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_valid", 0, 64'(ov[0]), 64'd1);
        checkOutput("t1_data", 0, dout[0], 64'h02D);
        checkOutput("t2_data", 1, dout[1], 64'h09D);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_pulse", 0, 64'(ov[0]), 64'd0);

        $display("[TB] back-to-back frames with output stall");
        sendFrame(64'h15, 64'h1F, 64'h03, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h11, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1, 64'h1C, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_held", 0, dout[0], 64'h02D);
        applyStimulus(1'b1, 1'b1, 64'h1C, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] in_last on the wrong part");
        applyStimulus(1'b1, 1'b0, 64'h15, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 64'h1F, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 64'h03, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_data", 0, dout[0], 64'h02D);

        $display("[TB] clear mid-frame with a pending output");
        sendFrame(64'h07, 64'h19, 64'h0E, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h1A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h05, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h1B, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h15, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h1F, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 64'h03, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_fresh", 0, dout[0], 64'h02D);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] asynchronous reset mid-frame");
        sendFrame(64'h0C, 64'h13, 64'h1D, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h09, 1'b0, 1'b0, 1'b0);
        resetMidFrame();
        sendFrame(64'h15, 64'h1F, 64'h03, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_after_reset", 0, dout[0], 64'h02D);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) resetMidFrame();
            c    = ($urandom_range(0, 99) < 3);
            flip = !c && ($urandom_range(0, 9) == 0);
            applyStimulus($urandom_range(0, 9) < 7, (m_idx == 2) ^ flip, 64'd0, 1'b1,
                          $urandom_range(0, 9) < 7, c);
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) checkOutput("drain", k, 64'(exp_q[k].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
